filter_gatherer: RTL and testbench

//  Downstream counterpart of the window recycler in the wrd conv path.
//  The conv datapath emits one scalar per window per filter, one whole pass per filter:
//  NUM_FILTERS passes of FRAME_LEN signed scalars.

---
 rtl/wrd_pkg.sv | 21 ++
 rtl/gather_buffer.sv | 58 +++++
 rtl/filter_gatherer.sv | 163 ++++++++++++++++
 tb/tb_filter_gatherer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrd_pkg.sv
// Shared definitions for the wrd conv path (window recycler / filter gatherer).
// Holds the default geometry shared by both blocks, the gatherer FSM state
// type and a counter-width helper.
package wrd_pkg;

    localparam int BW_DEF          = 8;
    localparam int FRAME_LEN_DEF   = 50;
    localparam int NUM_FILTERS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } wrd_state_e;

    // Width of a counter/index spanning 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gather_buffer.sv
// Row buffer for the filter gatherer: DEPTH rows of LANES*BW bits.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset (read register only)
//   wr_lane_en_i      per-lane write enable for row wr_addr_i
//   wr_addr_i         write row
//   wr_data_i         scalar written into every enabled lane
//   rd_en_i           load rd_data_o from row rd_addr_i on the next edge
//   rd_addr_i         read row
//   rd_data_o         registered read data, holds while rd_en_i=0
// Storage contents are not reset.
module gather_buffer
    import wrd_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int DEPTH = FRAME_LEN_DEF,
    parameter int LANES = NUM_FILTERS_DEF,
    localparam int AW   = cnt_w(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [LANES-1:0]      wr_lane_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [BW-1:0]         wr_data_i,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [LANES*BW-1:0]   rd_data_o
);

    logic [LANES*BW-1:0] mem [DEPTH];
    logic [LANES*BW-1:0] rd_data_q;
    logic [LANES*BW-1:0] rd_data_d;

    always_ff @(posedge clk_i) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (wr_lane_en_i[l]) begin
                mem[wr_addr_i][l*BW +: BW] <= wr_data_i;
            end
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem[rd_addr_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/filter_gatherer.sv
// Filter gatherer: collects NUM_FILTERS passes of FRAME_LEN signed scalars
// (one pass per filter) and streams FRAME_LEN vectors of NUM_FILTERS lanes.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   data_i/valid_i/last_i/ready_o   scalar input stream (last_i only checked)
//   data_o/valid_o/last_o/ready_i   vector output stream, lane f at [f*BW +: BW]
//   err_o          sticky: last_i disagreed with the window count on an accept
module filter_gatherer
    import wrd_pkg::*;
#(
    parameter int BW          = BW_DEF,
    parameter int FRAME_LEN   = FRAME_LEN_DEF,
    parameter int NUM_FILTERS = NUM_FILTERS_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [BW-1:0]               data_i,
    input  logic                        valid_i,
    input  logic                        last_i,
    output logic                        ready_o,
    output logic [NUM_FILTERS*BW-1:0]   data_o,
    output logic                        valid_o,
    output logic                        last_o,
    input  logic                        ready_i,
    output logic                        err_o
);

    localparam int WIN_W = cnt_w(FRAME_LEN);
    localparam int FLT_W = cnt_w(NUM_FILTERS);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(FRAME_LEN - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(NUM_FILTERS - 1);

    wrd_state_e         state_q, state_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [FLT_W-1:0]   flt_cnt_q, flt_cnt_d;
    logic [WIN_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               err_q, err_d;

    logic                   accept;
    logic                   emit;
    logic                   wr_en;
    logic [NUM_FILTERS-1:0] wr_lane_en;
    logic                   rd_en;
    logic [WIN_W-1:0]       rd_addr;
    logic [WIN_W-1:0]       rd_next;

    // Single-buffered: input is only taken outside DRAIN, and never during reset.
    assign ready_o = ~rst_i & (state_q != ST_DRAIN);
    assign accept  = valid_i & ready_o;
    assign emit    = valid_q & ready_i;
    assign rd_next = rd_cnt_q + WIN_W'(1);

    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        flt_cnt_d = flt_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        valid_d   = valid_q;
        last_d    = last_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = rd_cnt_q;

        case (state_q)
            // IDLE and COLLECT share the accept path: counters are 0 in IDLE,
            // so the first accept lands in lane 0 of row 0.
            ST_IDLE, ST_COLLECT: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    state_d = ST_COLLECT;
                    if (last_i != (win_cnt_q == WIN_LAST)) begin
                        err_d = 1'b1;
                    end
                    if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        if (flt_cnt_q == FLT_LAST) begin
                            // Frame complete: prefetch row 0 so valid_o rises next cycle.
                            flt_cnt_d = '0;
                            rd_cnt_d  = '0;
                            rd_en     = 1'b1;
                            rd_addr   = '0;
                            valid_d   = 1'b1;
                            last_d    = (FRAME_LEN == 1);
                            state_d   = ST_DRAIN;
                        end else begin
                            flt_cnt_d = flt_cnt_q + FLT_W'(1);
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                if (emit) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        rd_cnt_d = rd_next;
                        rd_en    = 1'b1;
                        rd_addr  = rd_next;
                        last_d   = (rd_next == WIN_LAST);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        for (int unsigned l = 0; l < NUM_FILTERS; l++) begin
            wr_lane_en[l] = wr_en && (flt_cnt_q == FLT_W'(l));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
            flt_cnt_q <= '0;
            rd_cnt_q  <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            flt_cnt_q <= flt_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    gather_buffer #(
        .BW    (BW),
        .DEPTH (FRAME_LEN),
        .LANES (NUM_FILTERS)
    ) u_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_lane_en_i (wr_lane_en),
        .wr_addr_i    (win_cnt_q),
        .wr_data_i    (data_i),
        .rd_en_i      (rd_en),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (data_o)
    );

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_filter_gatherer.sv
module tb_filter_gatherer;

    localparam int BW = 8;
    localparam int FL = 4;
    localparam int NF = 3;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [BW-1:0]     data_i;
    logic              valid_i;
    logic              last_i;
    logic              ready_o;
    logic [NF*BW-1:0]  data_o;
    logic              valid_o;
    logic              last_o;
    logic              ready_i;
    logic              err_o;

    always #5 clk = ~clk;

    filter_gatherer #(
        .BW          (BW),
        .FRAME_LEN   (FL),
        .NUM_FILTERS (NF)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .ready_i (ready_i),
        .err_o   (err_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame_d[f][t] is the scalar of filter f, window t.
    // Output row t is the concatenation of frame_d[0..NF-1][t], filter 0 in LSBs.
    typedef struct {
        logic [NF*BW-1:0] d;
        logic             l;
    } row_t;

    row_t             exp_q[$];
    logic [BW-1:0]    frame_d [NF][FL];
    logic             err_exp;
    int               mon_row;
    int               rdy_mode;
    int               stall_left;
    logic             prev_v, prev_r, prev_l;
    logic [NF*BW-1:0] prev_d;

    task automatic fill_pattern(input logic [BW-1:0] base);
        for (int f = 0; f < NF; f++)
            for (int t = 0; t < FL; t++)
                frame_d[f][t] = base + BW'(16 * f + t);
    endtask

    task automatic fill_random();
        for (int f = 0; f < NF; f++)
            for (int t = 0; t < FL; t++)
                frame_d[f][t] = BW'($urandom);
    endtask

    task automatic push_rows();
        row_t r;
        for (int t = 0; t < FL; t++) begin
            r.d = '0;
            for (int f = 0; f < NF; f++) r.d[f*BW +: BW] = frame_d[f][t];
            r.l = (t == FL - 1);
            exp_q.push_back(r);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send_scalar(input logic [BW-1:0] d, input logic l, input bit is_final,
                               output int waits);
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        waits   = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (is_final) check_val("valid_before_final", {31'd0, valid_o}, 32'd0);
            if (ready_o) break;
            waits++;
        end
        if (waits >= 200) check_val("accept_timeout", waits, 0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        if (is_final) check_val("valid_after_final", {31'd0, valid_o}, 32'd1);
    endtask

    task automatic send_frame(input int gap_mode, input int flip_f, input int flip_t,
                              input bit flip_rand, output int first_waits);
        logic l;
        bit   fin;
        int   w;
        first_waits = 0;
        for (int f = 0; f < NF; f++) begin
            for (int t = 0; t < FL; t++) begin
                l = (t == FL - 1);
                if ((f == flip_f && t == flip_t) || (flip_rand && $urandom_range(0, 15) == 0))
                    l = ~l;
                if (l != (t == FL - 1)) err_exp = 1'b1;
                fin = (f == NF - 1) && (t == FL - 1);
                send_scalar(frame_d[f][t], l, fin, w);
                if (f == 0 && t == 0) first_waits = w;
                check_val("err_o", {31'd0, err_o}, {31'd0, err_exp});
                if (fin) push_rows();
                if (gap_mode == 1) begin
                    @(posedge clk);
                    #1;
                end else if (gap_mode == 2) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0 && !valid_o) break;
            @(posedge clk);
            #1;
        end
        check_val("drain_rows_left", exp_q.size(), 0);
    endtask

    // Output monitor: sampled on the falling edge, so valid_o & ready_i here
    // means an emit on the coming rising edge.
    always @(negedge clk) begin
        row_t e;
        if (!rst_i) begin
            if (prev_v && !prev_r) begin
                check_val("hold_data", data_o, prev_d);
                check_val("hold_last", {31'd0, last_o}, {31'd0, prev_l});
                check_val("hold_valid", {31'd0, valid_o}, 32'd1);
            end
            if (valid_o) check_val("ready_in_drain", {31'd0, ready_o}, 32'd0);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_row", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("row_data", data_o, e.d);
                    check_val("row_last", {31'd0, last_o}, {31'd0, e.l});
                end
                mon_row = last_o ? 0 : mon_row + 1;
            end
            prev_v = valid_o;
            prev_r = ready_i;
            prev_d = data_o;
            prev_l = last_o;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: ready_i = ($urandom_range(0, 3) != 0);
            2: begin
                if (valid_o && mon_row == 1 && stall_left > 0) begin
                    ready_i = 1'b0;
                    stall_left--;
                end else begin
                    ready_i = 1'b1;
                end
            end
            default: ready_i = 1'b1;
        endcase
    end

    initial begin
        int w;
        rst_i      = 1'b1;
        valid_i    = 1'b0;
        data_i     = '0;
        last_i     = 1'b0;
        ready_i    = 1'b1;
        rdy_mode   = 0;
        stall_left = 0;
        err_exp    = 1'b0;
        mon_row    = 0;
        prev_v     = 1'b0;
        prev_r     = 1'b1;
        prev_l     = 1'b0;
        prev_d     = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", {31'd0, ready_o}, 32'd0);
        check_val("rst_valid", {31'd0, valid_o}, 32'd0);
        check_val("rst_last", {31'd0, last_o}, 32'd0);
        check_val("rst_err", {31'd0, err_o}, 32'd0);
        check_val("rst_data", data_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_ready", {31'd0, ready_o}, 32'd1);

        // 1 happy path
        fill_pattern(8'h00);
        send_frame(0, -1, -1, 1'b0, w);
        wait_drain();
        check_val("happy_err", {31'd0, err_o}, 32'd0);

        // 2 backpressure on row 1
        fill_pattern(8'h00);
        rdy_mode   = 2;
        stall_left = 3;
        send_frame(0, -1, -1, 1'b0, w);
        wait_drain();
        check_val("stall_applied", stall_left, 0);
        rdy_mode = 0;

        // 3 input gaps
        fill_pattern(8'h00);
        send_frame(1, -1, -1, 1'b0, w);
        wait_drain();

        // 4 back-to-back frames
        fill_pattern(8'h00);
        send_frame(0, -1, -1, 1'b0, w);
        fill_pattern(8'h80);
        send_frame(0, -1, -1, 1'b0, w);
        check_val("b2b_wait_cycles", w, FL);
        wait_drain();

        // 5 last_i error at pass 1, t=2
        fill_pattern(8'h00);
        send_frame(0, 1, 2, 1'b0, w);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check_val("err_sticky", {31'd0, err_o}, 32'd1);

        // 6 reset mid-DRAIN after row 1 emitted
        fill_pattern(8'h00);
        send_frame(0, -1, -1, 1'b0, w);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #2;
            if (mon_row >= 2) break;
        end
        check_val("reach_row2", mon_row, 2);
        rst_i = 1'b1;
        exp_q.delete();
        mon_row = 0;
        prev_v  = 1'b0;
        err_exp = 1'b0;
        #1;
        check_val("midrst_valid", {31'd0, valid_o}, 32'd0);
        check_val("midrst_last", {31'd0, last_o}, 32'd0);
        check_val("midrst_err", {31'd0, err_o}, 32'd0);
        check_val("midrst_ready", {31'd0, ready_o}, 32'd0);
        @(posedge clk);
        #3;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check_val("postrst_ready", {31'd0, ready_o}, 32'd1);
        fill_pattern(8'h40);
        send_frame(0, -1, -1, 1'b0, w);
        wait_drain();

        // Randomized frames: random data, gaps, backpressure and last_i errors
        rdy_mode = 1;
        for (int k = 0; k < 8; k++) begin
            fill_random();
            send_frame(2, -1, -1, 1'b1, w);
        end
        wait_drain();
        rdy_mode = 0;
        check_val("final_err", {31'd0, err_o}, {31'd0, err_exp});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
